// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial 11011 detector among N_REQ requesters.
// Each granted word is streamed MSB-first into the detector, detector match
// pulses are counted, and the count is reported together with the requester id.
module seq_det_sched #(
    parameter int unsigned   N_REQ = 4,
    parameter int unsigned   W     = 8,
    parameter int unsigned   CNT_W = 4,
    localparam int unsigned  ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 det_rst,
    output logic                 det_data,
    input  logic                 det_op,
    output logic                 done,
    output logic [ID_W-1:0]      done_id,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int unsigned IDX_W = ID_W + 1;
    localparam int unsigned BIT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    win_q, win_d;
    logic [W-1:0]       word_q, word_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               det_rst_q, det_rst_d;
    logic               det_data_q, det_data_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

    logic               any_req;
    logic [ID_W-1:0]    win_idx;
    logic [IDX_W-1:0]   idx_sum;

    // Round-robin winner: first asserted request at ptr, ptr+1, ... (mod N_REQ)
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        idx_sum = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx_sum = {1'b0, ptr_q} + IDX_W'(i);
            if (idx_sum >= IDX_W'(N_REQ)) begin
                idx_sum = idx_sum - IDX_W'(N_REQ);
            end
            if (!any_req && req[idx_sum[ID_W-1:0]]) begin
                any_req = 1'b1;
                win_idx = idx_sum[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        word_d      = word_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        det_data_d  = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    word_d         = req_data[int'(win_idx)*W +: W];
                    win_d          = win_idx;
                    ptr_d          = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                    gnt_d[win_idx] = 1'b1;
                    state_d        = S_CLR;
                end
            end
            S_CLR: begin
                cnt_d      = '0;
                bit_d      = '0;
                det_data_d = word_q[W-1];
                word_d     = {word_q[W-2:0], 1'b0};
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                // op in the first shift cycle still reflects the cleared detector
                if ((bit_q != '0) && det_op && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bit_q == BIT_W'(W - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    bit_d      = bit_q + BIT_W'(1);
                    det_data_d = word_q[W-1];
                    word_d     = {word_q[W-2:0], 1'b0};
                end
            end
            S_DRAIN: begin
                if (det_op && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                done_d      = 1'b1;
                done_id_d   = win_q;
                match_cnt_d = cnt_d;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        det_rst_d = (state_d == S_IDLE) || (state_d == S_CLR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            word_q      <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            det_rst_q   <= 1'b1;
            det_data_q  <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            word_q      <= word_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            det_rst_q   <= det_rst_d;
            det_data_q  <= det_data_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign det_rst   = det_rst_q;
    assign det_data  = det_data_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a behavioural overlapping 11011 detector.
module tb_seq_det_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;

    logic [3:0]  gnt0, gnt1;
    logic        busy0, busy1;
    logic        det_rst0, det_rst1;
    logic        det_data0, det_data1;
    logic        det_op0, det_op1;
    logic        done0, done1;
    logic [1:0]  done_id0, done_id1;
    logic [3:0]  match_cnt0;
    logic [0:0]  match_cnt1;

    logic [2:0]  ds0, ds1;

    int checks;
    int errors;

    seq_det_sched #(.N_REQ(4), .W(8), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt0), .busy(busy0), .det_rst(det_rst0), .det_data(det_data0),
        .det_op(det_op0), .done(done0), .done_id(done_id0), .match_cnt(match_cnt0)
    );

    seq_det_sched #(.N_REQ(4), .W(8), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt1), .busy(busy1), .det_rst(det_rst1), .det_data(det_data1),
        .det_op(det_op1), .done(done1), .done_id(done_id1), .match_cnt(match_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping Moore 11011 detector: state = length of matched prefix
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd2 : 3'd0;
            3'd2:    return b ? 3'd2 : 3'd3;
            3'd3:    return b ? 3'd4 : 3'd0;
            3'd4:    return b ? 3'd5 : 3'd0;
            default: return b ? 3'd2 : 3'd3;
        endcase
    endfunction

    initial begin
        ds0 = 3'd0;
        ds1 = 3'd0;
    end
    always @(posedge clk) ds0 <= det_rst0 ? 3'd0 : det_next(ds0, det_data0);
    always @(posedge clk) ds1 <= det_rst1 ? 3'd0 : det_next(ds1, det_data1);
    assign det_op0 = (ds0 == 3'd5);
    assign det_op1 = (ds1 == 3'd5);

    // Issue one word from requester idx (DUT idle, at a negedge); returns at the DONE negedge
    task automatic run_word(input int idx, input logic [7:0] word,
                            output logic [3:0] gnt_seen, output int gnt_lat,
                            output int done_lat, output logic [1:0] id,
                            output logic [3:0] cnt0, output logic cnt1,
                            output logic [7:0] stream);
        gnt_seen = '0; gnt_lat = -1; done_lat = -1; id = '0; cnt0 = '0; cnt1 = 1'b0;
        stream = '0;
        req_data[idx*8 +: 8] = word;
        req = 4'b0001 << idx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (gnt_lat < 0 && gnt0 != 4'b0000) begin
                gnt_lat = n; gnt_seen = gnt0; req = 4'b0000;
            end
            if (n >= 2 && n <= 9) stream = {stream[6:0], det_data0};
            if (done0) begin
                done_lat = n; id = done_id0; cnt0 = match_cnt0; cnt1 = match_cnt1[0];
                break;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy0); end
        checks++; if (det_rst0 !== 1'b1) begin errors++; $display("FAIL rst_det_rst got %b exp 1", det_rst0); end
        checks++; if (det_data0 !== 1'b0) begin errors++; $display("FAIL rst_det_data got %b exp 0", det_data0); end
        checks++; if (done0 !== 1'b0 || done_id0 !== 2'd0 || match_cnt0 !== 4'd0) begin
            errors++; $display("FAIL rst_done got %b/%0d/%0d exp 0/0/0", done0, done_id0, match_cnt0); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] g; int gl, dl; logic [1:0] id; logic [3:0] c0; logic c1; logic [7:0] st;
        run_word(0, 8'b11011011, g, gl, dl, id, c0, c1, st);
        checks++; if (g !== 4'b0001 || gl != 1) begin errors++; $display("FAIL t1_gnt got %b@%0d exp 0001@1", g, gl); end
        checks++; if (dl != 11) begin errors++; $display("FAIL t1_done_lat got %0d exp 11", dl); end
        checks++; if (id !== 2'd0 || c0 !== 4'd2) begin errors++; $display("FAIL t1_result got id%0d cnt%0d exp id0 cnt2", id, c0); end
        checks++; if (st !== 8'b11011011) begin errors++; $display("FAIL t1_stream got %b exp 11011011", st); end
        @(negedge clk);
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b0 || det_rst0 !== 1'b1) begin
            errors++; $display("FAIL t1_after got done%b busy%b rst%b exp 0 0 1", done0, busy0, det_rst0); end
        checks++; if (match_cnt0 !== 4'd2) begin errors++; $display("FAIL t1_hold got %0d exp 2", match_cnt0); end
    endtask

    task automatic test_patterns();
        logic [3:0] g; int gl, dl; logic [1:0] id; logic [3:0] c0; logic c1; logic [7:0] st;
        logic [7:0] words [3] = '{8'h00, 8'hFF, 8'b00011011};
        int exp_c [3] = '{0, 0, 1};
        for (int k = 0; k < 3; k++) begin
            run_word(2, words[k], g, gl, dl, id, c0, c1, st);
            checks++; if (g !== 4'b0100 || dl != 11) begin errors++; $display("FAIL t2_timing[%0d] got %b done@%0d exp 0100 done@11", k, g, dl); end
            checks++; if (id !== 2'd2 || c0 !== 4'(exp_c[k])) begin
                errors++; $display("FAIL t2_result[%0d] got id%0d cnt%0d exp id2 cnt%0d", k, id, c0, exp_c[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseq [5]; int dcyc [5]; logic [1:0] did [5]; logic [3:0] dcnt [5];
        int exp_c [5] = '{2, 1, 0, 0, 2};
        int ng, nd; logic overlap;
        ng = 0; nd = 0; overlap = 1'b0;
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        req_data = {8'h00, 8'hFF, 8'b00011011, 8'b11011011};
        req = 4'b1111;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (gnt0 != 4'b0000 && done0) overlap = 1'b1;
            if (gnt0 != 4'b0000 && ng < 5) begin
                gseq[ng] = gnt0; ng++;
                if (ng == 5) req = 4'b0000;
            end
            if (done0 && nd < 5) begin
                dcyc[nd] = n; did[nd] = done_id0; dcnt[nd] = match_cnt0; nd++;
            end
            if (nd == 5) break;
        end
        req = 4'b0000;
        checks++; if (ng != 5 || nd != 5) begin errors++; $display("FAIL t3_count got g%0d d%0d exp 5 5", ng, nd); end
        else begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (gseq[k] !== (4'b0001 << (k % 4))) begin
                    errors++; $display("FAIL t3_gnt[%0d] got %b exp %b", k, gseq[k], 4'b0001 << (k % 4)); end
                checks++; if (did[k] !== 2'(k % 4) || dcnt[k] !== 4'(exp_c[k])) begin
                    errors++; $display("FAIL t3_done[%0d] got id%0d cnt%0d exp id%0d cnt%0d", k, did[k], dcnt[k], k % 4, exp_c[k]); end
                if (k > 0) begin
                    checks++; if (dcyc[k] - dcyc[k-1] != 12) begin
                        errors++; $display("FAIL t3_spacing[%0d] got %0d exp 12", k, dcyc[k] - dcyc[k-1]); end
                end
            end
        end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL t3_gnt_done_overlap got 1 exp 0"); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [3:0] g; int gl, dl; logic [1:0] id; logic [3:0] c0; logic c1; logic [7:0] st;
        run_word(0, 8'b11011011, g, gl, dl, id, c0, c1, st);
        checks++; if (dl != 11 || c1 !== 1'b1) begin errors++; $display("FAIL t4_sat got cnt%b done@%0d exp cnt1 done@11", c1, dl); end
        checks++; if (c0 !== 4'd2) begin errors++; $display("FAIL t4_wide got %0d exp 2", c0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic saw_done; int dl;
        saw_done = 1'b0; dl = -1;
        req_data[15:8] = 8'b11011011;
        req = 4'b0010;
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL t5_gnt got %b exp 0010", gnt0); end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (gnt0 !== 4'b0000 || busy0 !== 1'b0 || det_rst0 !== 1'b1 || det_data0 !== 1'b0) begin
            errors++; $display("FAIL t5_async got gnt%b busy%b rst%b data%b exp 0000 0 1 0", gnt0, busy0, det_rst0, det_data0); end
        checks++; if (done0 !== 1'b0 || done_id0 !== 2'd0 || match_cnt0 !== 4'd0) begin
            errors++; $display("FAIL t5_result got %b/%0d/%0d exp 0/0/0", done0, done_id0, match_cnt0); end
        repeat (12) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL t5_no_done got 1 exp 0"); end
        rst = 1'b1;
        req_data[7:0] = 8'b00011011;
        req = 4'b0011;
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL t5_regrant got %b exp 0001", gnt0); end
        req = 4'b0000;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (done0) begin dl = n; break; end
        end
        checks++; if (dl != 11 || done_id0 !== 2'd0 || match_cnt0 !== 4'd1) begin
            errors++; $display("FAIL t5_word got done@%0d id%0d cnt%0d exp 11 0 1", dl, done_id0, match_cnt0); end
        @(negedge clk);
        // abort a grant to requester 1, then a 1010 request must restart at index 0
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1010;
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL t5_ptr_reset got %b exp 0010", gnt0); end
        req = 4'b0000;
        dl = -1;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (done0) begin dl = n; break; end
        end
        checks++; if (dl != 11 || done_id0 !== 2'd1) begin errors++; $display("FAIL t5_word2 got done@%0d id%0d exp 11 1", dl, done_id0); end
        @(negedge clk);
    endtask

    task automatic test_no_carry();
        logic [3:0] g; int gl, dl; logic [1:0] id; logic [3:0] c0; logic c1; logic [7:0] st;
        run_word(0, 8'b00000110, g, gl, dl, id, c0, c1, st);
        checks++; if (dl != 11 || c0 !== 4'd0) begin errors++; $display("FAIL t6_first got cnt%0d done@%0d exp 0 11", c0, dl); end
        @(negedge clk);
        checks++; if (det_rst0 !== 1'b1) begin errors++; $display("FAIL t6_det_rst got %b exp 1", det_rst0); end
        run_word(0, 8'b11000000, g, gl, dl, id, c0, c1, st);
        checks++; if (dl != 11 || c0 !== 4'd0) begin errors++; $display("FAIL t6_second got cnt%0d done@%0d exp 0 11", c0, dl); end
        checks++; if (st !== 8'b11000000) begin errors++; $display("FAIL t6_stream got %b exp 11000000", st); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_patterns();
        test_round_robin();
        test_saturate();
        test_reset_mid();
        test_no_carry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
